// File: rtl/rem_line_packer_pkg.sv
// Purpose : shared constants, FSM state type and line helper for the regex-engine line packer.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package rem_line_packer_pkg;

   localparam int LINE_BYTES   = 64;
   localparam int HDR_BYTES    = 2;
   localparam int MAX_DATA_LEN = 65533;
   localparam int LINE_W       = LINE_BYTES * 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      SEND = 2'd2
   } state_t;

   // A whole line with every byte set to the pad value.
   function automatic logic [LINE_W-1:0] fill_line(input logic [7:0] pad);
      return {LINE_BYTES{pad}};
   endfunction

endpackage

// File: rtl/rem_line_packer.sv
// Purpose : packs a length word plus a byte stream into 512-bit lines for the regex engine;
//           line 0 carries header H=len+2 (LE, bytes 0-1), unused tail bytes are DELIMITER.
// Latency : a line is offered one cycle after its final byte (or after a zero length) is accepted.
// Backpressure: output_ready low holds SEND with output_data stable and char_ready low.
//
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   len_valid/len_data/len_ready      - string length handshake (16-bit data-byte count)
//   char_valid/char_data/char_ready   - string byte handshake
//   output_valid/output_data/output_ready - 512-bit line handshake, byte k at [8k+7:8k]
//   err_len                           - one-cycle pulse when a length above MAX_DATA_LEN is rejected
//   strings_sent                      - wrapping count of fully emitted strings
module rem_line_packer
   import rem_line_packer_pkg::*;
#(
   parameter logic [7:0] DELIMITER = 8'h00
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         len_valid,
   input  logic [15:0]  len_data,
   output logic         len_ready,
   input  logic         char_valid,
   input  logic [7:0]   char_data,
   output logic         char_ready,
   output logic         output_valid,
   output logic [511:0] output_data,
   input  logic         output_ready,
   output logic         err_len,
   output logic [31:0]  strings_sent
);

   state_t          state, state_n;
   logic [LINE_W-1:0] line;
   logic [6:0]      ptr;
   logic [15:0]     remaining;

   logic            len_fire, char_fire, out_fire, len_bad, last_byte;
   logic [15:0]     hdr_word;
   logic            len_ready_n, char_ready_n, output_valid_n;

   assign len_fire  = len_valid & len_ready;
   assign char_fire = char_valid & char_ready;
   assign out_fire  = output_valid & output_ready;
   assign len_bad   = len_data > 16'(MAX_DATA_LEN);
   // Final byte of a line: either the line is full or the string is exhausted.
   assign last_byte = (ptr == 7'(LINE_BYTES - 1)) || (remaining == 16'd1);
   // A zero-length string carries header 0, not 2. Bound on len_data keeps the sum in 16 bits.
   assign hdr_word  = (len_data == 16'd0) ? 16'd0 : len_data + 16'(HDR_BYTES);

   assign output_data = line;

   // Next-state logic.
   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (len_fire && !len_bad)
               state_n = (len_data == 16'd0) ? SEND : FILL;
         end
         FILL: begin
            if (char_fire && last_byte)
               state_n = SEND;
         end
         SEND: begin
            if (out_fire)
               state_n = (remaining != 16'd0) ? FILL : IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Handshake outputs are decoded from the next state and then registered,
   // so they line up with the state they describe and are all flop outputs.
   always_comb begin
      len_ready_n    = (state_n == IDLE);
      char_ready_n   = (state_n == FILL);
      output_valid_n = (state_n == SEND);
   end

   // State, output and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         len_ready    <= 1'b0;
         char_ready   <= 1'b0;
         output_valid <= 1'b0;
         err_len      <= 1'b0;
         strings_sent <= 32'd0;
         ptr          <= 7'd0;
         remaining    <= 16'd0;
         line         <= fill_line(DELIMITER);
      end else begin
         state        <= state_n;
         len_ready    <= len_ready_n;
         char_ready   <= char_ready_n;
         output_valid <= output_valid_n;
         err_len      <= len_fire & len_bad;

         case (state)
            IDLE: begin
               if (len_fire && !len_bad) begin
                  // Later assignment to bits 15:0 overrides the pad fill there.
                  line       <= fill_line(DELIMITER);
                  line[15:0] <= hdr_word;
                  ptr        <= 7'(HDR_BYTES);
                  remaining  <= len_data;
               end
            end
            FILL: begin
               if (char_fire) begin
                  line[{ptr[5:0], 3'b000} +: 8] <= char_data;
                  ptr       <= ptr + 7'd1;
                  remaining <= remaining - 16'd1;
               end
            end
            SEND: begin
               if (out_fire) begin
                  if (remaining != 16'd0) begin
                     line <= fill_line(DELIMITER);
                     ptr  <= 7'd0;
                  end else begin
                     strings_sent <= strings_sent + 32'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rem_line_packer.sv
// Purpose : self-checking bench for rem_line_packer using directed strings.
// Latency : n/a.
// Backpressure: exercises output_ready stalls during SEND.
module tb_rem_line_packer;

   localparam logic [7:0] DELIM = 8'h2E;

   logic         clk = 1'b0;
   logic         rst;
   logic         len_valid;
   logic [15:0]  len_data;
   logic         len_ready;
   logic         char_valid;
   logic [7:0]   char_data;
   logic         char_ready;
   logic         output_valid;
   logic [511:0] output_data;
   logic         output_ready;
   logic         err_len;
   logic [31:0]  strings_sent;

   int tests = 0;
   int fails = 0;

   logic [7:0]   msg [0:255];
   logic [511:0] got [$];
   int           cr_seen;
   int           stall_bad;
   int           stall_seen;

   rem_line_packer #(.DELIMITER(DELIM)) dut (
      .clk          (clk),
      .rst          (rst),
      .len_valid    (len_valid),
      .len_data     (len_data),
      .len_ready    (len_ready),
      .char_valid   (char_valid),
      .char_data    (char_data),
      .char_ready   (char_ready),
      .output_valid (output_valid),
      .output_data  (output_data),
      .output_ready (output_ready),
      .err_len      (err_len),
      .strings_sent (strings_sent)
   );

   always #5 clk = ~clk;

   // Reference line k of a string of length l built from msg[].
   function automatic logic [511:0] exp_line(input int l, input int k);
      logic [511:0] r;
      int h;
      int pos;
      r = {64{DELIM}};
      if (k == 0) begin
         h = (l == 0) ? 0 : l + 2;
         r[7:0]  = h[7:0];
         r[15:8] = h[15:8];
         for (int b = 2; b < 64; b++)
            if (b - 2 < l) r[8*b +: 8] = msg[b-2];
      end else begin
         for (int b = 0; b < 64; b++) begin
            pos = 62 + 64*(k-1) + b;
            if (pos < l) r[8*b +: 8] = msg[pos];
         end
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a length and return one cycle after it is accepted (at #1 past that edge).
   task automatic send_len(input logic [15:0] l);
      int n;
      len_valid = 1'b1;
      len_data  = l;
      n = 0;
      while (!len_ready && n < 50) begin
         tick();
         n++;
      end
      if (!len_ready) begin
         tests++; fails++;
         $display("FAIL len_accept_timeout: len_ready=%0b required 1", len_ready);
      end
      tick();
      len_valid = 1'b0;
   endtask

   // Send a whole string of length l from msg[], collecting lines into got[].
   // The first SEND is held off for 'stall' cycles.
   task automatic drive_string(input int l, input int stall);
      int n;
      int idx;
      int stall_left;
      logic [511:0] snap;
      got.delete();
      cr_seen = 0; stall_bad = 0; stall_seen = 0;
      snap = '0;
      send_len(l[15:0]);
      idx = 0; stall_left = stall; n = 0;
      while (!len_ready && n < 2000) begin
         if (char_ready) cr_seen = 1;
         if (char_ready && idx < l) begin
            char_valid = 1'b1;
            char_data  = msg[idx];
         end else begin
            char_valid = 1'b0;
         end
         if (output_valid) begin
            if (stall_left > 0) begin
               if (stall_left == stall) snap = output_data;
               else if (output_data !== snap) stall_bad++;
               if (char_ready) stall_bad++;
               output_ready = 1'b0;
               stall_left--;
               stall_seen++;
            end else begin
               output_ready = 1'b1;
               got.push_back(output_data);
            end
         end else begin
            output_ready = 1'b1;
         end
         tick();
         n++;
         if (char_valid) idx++;
      end
      char_valid   = 1'b0;
      output_ready = 1'b1;
      if (!len_ready) begin
         tests++; fails++;
         $display("FAIL string_done_timeout: len_ready=%0b required 1 (len %0d)", len_ready, l);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      len_valid = 1'b0; len_data = '0;
      char_valid = 1'b0; char_data = '0;
      output_ready = 1'b1;
      repeat (3) tick();
      tests++; if (output_valid !== 1'b0) begin fails++; $display("FAIL rst_output_valid: got %0b want 0", output_valid); end
      tests++; if (char_ready !== 1'b0)   begin fails++; $display("FAIL rst_char_ready: got %0b want 0", char_ready); end
      tests++; if (len_ready !== 1'b0)    begin fails++; $display("FAIL rst_len_ready: got %0b want 0", len_ready); end
      tests++; if (err_len !== 1'b0)      begin fails++; $display("FAIL rst_err_len: got %0b want 0", err_len); end
      tests++; if (strings_sent !== 32'd0) begin fails++; $display("FAIL rst_strings_sent: got %0d want 0", strings_sent); end
      rst = 1'b0;
      tick();
      tests++; if (len_ready !== 1'b1) begin fails++; $display("FAIL post_rst_len_ready: got %0b want 1", len_ready); end
   endtask

   task automatic test_basic();
      logic [511:0] l0;
      msg[0] = "a"; msg[1] = "b"; msg[2] = "c"; msg[3] = "d"; msg[4] = "e";
      drive_string(5, 0);
      l0 = (got.size() > 0) ? got[0] : '0;
      tests++; if (got.size() != 1) begin fails++; $display("FAIL basic_line_count: got %0d want 1", got.size()); end
      tests++; if (l0[15:0] !== 16'h0007) begin fails++; $display("FAIL basic_header: got %h want 0007", l0[15:0]); end
      tests++; if (l0[55:16] !== 40'h6564636261) begin fails++; $display("FAIL basic_data: got %h want 6564636261", l0[55:16]); end
      tests++; if (l0[511:56] !== {57{DELIM}}) begin fails++; $display("FAIL basic_pad: got %h", l0[511:56]); end
      tests++; if (strings_sent !== 32'd1) begin fails++; $display("FAIL basic_strings_sent: got %0d want 1", strings_sent); end
   endtask

   task automatic test_boundary();
      logic [511:0] l0, l1;
      for (int i = 0; i < 256; i++) msg[i] = 8'(8'h20 + i);
      drive_string(62, 0);
      l0 = (got.size() > 0) ? got[0] : '0;
      tests++; if (got.size() != 1) begin fails++; $display("FAIL l62_line_count: got %0d want 1", got.size()); end
      tests++; if (l0[15:0] !== 16'h0040) begin fails++; $display("FAIL l62_header: got %h want 0040", l0[15:0]); end
      tests++; if (l0 !== exp_line(62, 0)) begin fails++; $display("FAIL l62_line: got %h want %h", l0, exp_line(62, 0)); end
      drive_string(63, 0);
      l0 = (got.size() > 0) ? got[0] : '0;
      l1 = (got.size() > 1) ? got[1] : '0;
      tests++; if (got.size() != 2) begin fails++; $display("FAIL l63_line_count: got %0d want 2", got.size()); end
      tests++; if (l0[15:0] !== 16'h0041) begin fails++; $display("FAIL l63_header: got %h want 0041", l0[15:0]); end
      tests++; if (l0 !== exp_line(63, 0)) begin fails++; $display("FAIL l63_line0: got %h want %h", l0, exp_line(63, 0)); end
      tests++; if (l1[7:0] !== 8'h5E) begin fails++; $display("FAIL l63_line1_byte0: got %h want 5e", l1[7:0]); end
      tests++; if (l1[511:8] !== {63{DELIM}}) begin fails++; $display("FAIL l63_line1_pad: got %h", l1[511:8]); end
      tests++; if (strings_sent !== 32'd3) begin fails++; $display("FAIL l63_strings_sent: got %0d want 3", strings_sent); end
   endtask

   task automatic test_zero_len();
      logic [511:0] l0;
      drive_string(0, 0);
      l0 = (got.size() > 0) ? got[0] : '0;
      tests++; if (got.size() != 1) begin fails++; $display("FAIL l0_line_count: got %0d want 1", got.size()); end
      tests++; if (l0 !== {{62{DELIM}}, 16'h0000}) begin fails++; $display("FAIL l0_line: got %h", l0); end
      tests++; if (cr_seen != 0) begin fails++; $display("FAIL l0_char_ready: got %0d want 0", cr_seen); end
      tests++; if (strings_sent !== 32'd4) begin fails++; $display("FAIL l0_strings_sent: got %0d want 4", strings_sent); end
   endtask

   task automatic test_err_len();
      send_len(16'd65534);
      tests++; if (err_len !== 1'b1) begin fails++; $display("FAIL err_pulse: got %0b want 1", err_len); end
      tests++; if (len_ready !== 1'b1) begin fails++; $display("FAIL err_len_ready: got %0b want 1", len_ready); end
      tests++; if (output_valid !== 1'b0) begin fails++; $display("FAIL err_output_valid: got %0b want 0", output_valid); end
      tick();
      tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL err_pulse_width: got %0b want 0", err_len); end
      tests++; if (char_ready !== 1'b0) begin fails++; $display("FAIL err_char_ready: got %0b want 0", char_ready); end
      tests++; if (strings_sent !== 32'd4) begin fails++; $display("FAIL err_strings_sent: got %0d want 4", strings_sent); end
   endtask

   task automatic test_stall();
      logic [511:0] l2;
      drive_string(130, 10);
      l2 = (got.size() > 2) ? got[2] : '0;
      tests++; if (got.size() != 3) begin fails++; $display("FAIL stall_line_count: got %0d want 3", got.size()); end
      tests++; if (stall_seen != 10) begin fails++; $display("FAIL stall_cycles: got %0d want 10", stall_seen); end
      tests++; if (stall_bad != 0) begin fails++; $display("FAIL stall_stability: got %0d bad cycles want 0", stall_bad); end
      for (int k = 0; k < 3; k++) begin
         if (k < got.size()) begin
            tests++;
            if (got[k] !== exp_line(130, k)) begin
               fails++; $display("FAIL stall_line%0d: got %h want %h", k, got[k], exp_line(130, k));
            end
         end
      end
      tests++; if (l2 !== {{60{DELIM}}, 32'hA1A09F9E}) begin fails++; $display("FAIL stall_line2_hand: got %h", l2); end
      tests++; if (strings_sent !== 32'd5) begin fails++; $display("FAIL stall_strings_sent: got %0d want 5", strings_sent); end
   endtask

   task automatic test_reset_mid_string();
      logic [511:0] l0;
      int ov_seen;
      ov_seen = 0;
      send_len(16'd100);
      for (int i = 0; i < 30; i++) begin
         if (output_valid) ov_seen++;
         char_valid = 1'b1;
         char_data  = msg[i];
         tick();
      end
      char_valid = 1'b0;
      rst = 1'b1;
      repeat (2) begin
         if (output_valid) ov_seen++;
         tick();
      end
      rst = 1'b0;
      tick();
      if (output_valid) ov_seen++;
      tests++; if (ov_seen != 0) begin fails++; $display("FAIL mid_rst_no_output: got %0d valid cycles want 0", ov_seen); end
      tests++; if (strings_sent !== 32'd0) begin fails++; $display("FAIL mid_rst_strings_sent: got %0d want 0", strings_sent); end
      msg[0] = "x"; msg[1] = "y"; msg[2] = "z";
      drive_string(3, 0);
      l0 = (got.size() > 0) ? got[0] : '0;
      tests++; if (got.size() != 1) begin fails++; $display("FAIL mid_rst_line_count: got %0d want 1", got.size()); end
      tests++; if (l0 !== {{59{DELIM}}, 24'h7A7978, 16'h0005}) begin fails++; $display("FAIL mid_rst_line: got %h", l0); end
      tests++; if (strings_sent !== 32'd1) begin fails++; $display("FAIL mid_rst_strings_after: got %0d want 1", strings_sent); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) msg[i] = 8'h00;
      test_reset();
      test_basic();
      test_boundary();
      test_zero_len();
      test_err_len();
      test_stall();
      test_reset_mid_string();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rem_line_packer.md
REM_LINE_PACKER -- requirements
Module: rem_line_packer

Interface
REQ-001 SHALL have parameter DELIMITER, default 0: 8-bit pad value for unused bytes of a string's final line.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous reset.
REQ-005 SHALL have port len_valid, input, 1: a string length is offered.
REQ-006 SHALL have port len_data, input, 16: data-byte count of the next string.
REQ-007 SHALL have port len_ready, output, 1: length accepted when len_valid and len_ready are both high.
REQ-008 SHALL have port char_valid, input, 1: a string byte is offered.
REQ-009 SHALL have port char_data, input, 8: string byte.
REQ-010 SHALL have port char_ready, output, 1: byte accepted when char_valid and char_ready are both high.
REQ-011 SHALL have port output_valid, output, 1: a 512-bit line is offered.
REQ-012 SHALL have port output_data, output, 512: line; byte k occupies bits [8k+7:8k].
REQ-013 SHALL have port output_ready, input, 1: line consumed when output_valid and output_ready are both high.
REQ-014 SHALL have port err_len, output, 1: one-cycle pulse when a length is rejected.
REQ-015 SHALL have port strings_sent, output, 32: count of completed strings, wrapping modulo 2^32.

Function
REQ-016 SHALL produce the line format consumed by the regex engine; line 0 carries the header H = len_data+2 in bytes 0-1, little-endian, and data in bytes 2-63.
REQ-017 SHALL put data in all 64 bytes of each subsequent line; the line count is ceil(H/64).
REQ-018 SHALL pad bytes after the last data byte of the final line with DELIMITER.
REQ-019 SHALL use states IDLE, FILL and SEND; all outputs are registered.
REQ-020 In IDLE, len_ready=1 and char_ready=0.
REQ-021 On an accepted length L with 1<=L<=65533, SHALL clear the line register to DELIMITER, write H into bytes 0-1, set byte pointer=2 and remaining=L, and go to FILL.
REQ-022 On accepted L=0, SHALL build one line with header 0 and bytes 2-63 set to DELIMITER, go to SEND, and consume no characters.
REQ-023 On accepted L>65533, SHALL pulse err_len the next cycle, consume no characters, and stay in IDLE.
REQ-024 In FILL, char_ready=1 and len_ready=0.
REQ-025 In FILL, each accepted byte SHALL be written at the pointer, the pointer SHALL increment, and remaining SHALL decrement.
REQ-026 SHALL go to SEND on the cycle after the byte that fills pointer 63 or drops remaining to 0.
REQ-027 SHALL sustain 1 byte/cycle throughput in FILL; char_valid low SHALL stall FILL with no state change.
REQ-028 In SEND, output_valid=1 and char_ready=0; output_data SHALL hold stable until output_ready.
REQ-029 On the SEND handshake, if remaining>0, SHALL reset the line register to DELIMITER, set pointer=0, and go to FILL.
REQ-030 On the SEND handshake, if remaining=0, SHALL increment strings_sent and go to IDLE.
REQ-031 Latency: the first line SHALL assert output_valid one cycle after its final byte (or after L=0) is accepted.
REQ-032 The pointer SHALL be 7 bits wide; the header sum SHALL be computed at 16 bits and can never overflow, given REQ-023.
REQ-033 char_valid pulses in IDLE or SEND SHALL be ignored and never stored.

Reset
REQ-034 While rst=1 SHALL hold state=IDLE and output_valid=0, char_ready=0, len_ready=0, err_len=0, strings_sent=0.
REQ-035 SHALL drive len_ready=1 on the first cycle after rst falls.
REQ-036 Reset mid-string SHALL discard the partial line with no output; the producer restarts from a length word.

Structure
REQ-037 A shared rem package SHALL hold LINE_BYTES=64, HDR_BYTES=2, MAX_DATA_LEN=65533, and the state enum.
REQ-038 SHALL be a single module with no sub-modules.

Verification
REQ-039 Bench SHALL cover: L=5, bytes "abcde", output_ready=1 -> one line, bytes0-1=0x0007, bytes2-6="abcde", bytes7-63=DELIMITER, strings_sent=1.
REQ-040 Bench SHALL cover: L=62 -> exactly one line, header 0x0040; then L=63 -> two lines, header 0x0041, line1 byte0=63rd char, bytes1-63 pad.
REQ-041 Bench SHALL cover: L=0 -> one line, header 0x0000, all other bytes DELIMITER, no char_ready.
REQ-042 Bench SHALL cover: L=65534 -> err_len pulse, no output, len_ready=1 again next cycle.
REQ-043 Bench SHALL cover: L=130 with output_ready low 10 cycles during SEND -> output_data stable throughout, three lines total, char_ready=0 while stalled.
REQ-044 Bench SHALL cover: rst asserted after 30 of 100 bytes -> no line emitted; a new L=3 string then produces a correct single line.
